// File: rtl/uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_pkg
// Shared definitions for the UART transmit engine:
//   - tx_state_t : FSM state encoding (IDLE, START, DATA, PARITY, STOP)
//   - line levels for start, stop and idle bits
//   - parity type codes (EVEN / ODD)
// -----------------------------------------------------------------------------
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Serial line levels
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic IDLE_BIT  = 1'b1;

    // Parity type codes as seen on PAR_TYP
    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

endpackage : uart_tx_pkg

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
// Holds the latched payload and the bit counter for one UART frame.
//
// Ports:
//   CLK        in   TX bit clock
//   RST        in   synchronous active-high reset
//   load       in   latch load_data (frame acceptance)
//   load_data  in   payload byte to latch
//   shift_en   in   advance to the next payload bit
//   cnt_clr    in   clear the bit counter (START state)
//   cnt_inc    in   increment the bit counter (DATA state, not last bit)
//   ser_data   out  next payload bit to be driven onto the line
//   ser_done   out  counter is on the last payload bit
//
// ser_data is always the LSB of the shift register. Because the line output
// is registered, the FSM samples ser_data one cycle ahead of the bit being
// shown, and the register is shifted on that same edge.
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  shift_en,
    input  logic                  cnt_clr,
    input  logic                  cnt_inc,
    output logic                  ser_data,
    output logic                  ser_done
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] data_reg;
    logic [CNT_W-1:0]      cnt_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            data_reg <= '0;
        end else if (load) begin
            data_reg <= load_data;
        end else if (shift_en) begin
            data_reg <= data_reg >> 1;
        end
    end

    // Counter tracks the index of the payload bit currently on the line.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_reg <= '0;
        end else if (load || cnt_clr) begin
            cnt_reg <= '0;
        end else if (cnt_inc) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign ser_data = data_reg[0];
    assign ser_done = (cnt_reg == LAST_BIT);

endmodule : uart_tx_serializer

// File: rtl/uart_tx_core.sv
// -----------------------------------------------------------------------------
// uart_tx_core
// UART transmit engine. Sends start bit, DATA_WIDTH data bits LSB first,
// optional parity and a stop bit, one bit per CLK cycle.
//
// Ports:
//   CLK         in   TX bit clock (already divided to the bit rate)
//   RST         in   synchronous active-high reset
//   P_DATA      in   byte to transmit, sampled on acceptance
//   Data_Valid  in   send request; accepted only in IDLE
//   PAR_EN      in   1 = insert parity bit, sampled on acceptance
//   PAR_TYP     in   0 = even, 1 = odd, sampled on acceptance
//   TX_OUT      out  registered serial line, idle high
//   busy        out  registered, high while a frame is on the line
//
// Both outputs are registered from the next-state decode, so the value shown
// in a cycle belongs to the state the FSM is in during that cycle and no input
// reaches an output combinationally.
// -----------------------------------------------------------------------------
module uart_tx_core
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy
);

    tx_state_t state_reg;
    tx_state_t state_next;

    logic tx_reg;
    logic tx_next;
    logic busy_reg;
    logic busy_next;

    logic par_en_reg;
    logic par_bit_reg;

    logic accept;
    logic ser_data;
    logic ser_done;
    logic shift_en;
    logic cnt_clr;
    logic cnt_inc;

    // -------------------------------------------------------------------------
    // Parity: XOR reduction of the incoming byte. Computed from P_DATA in the
    // acceptance cycle, which is the same value the serializer latches.
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] par_chain;

    assign par_chain[0] = P_DATA[0];

    generate
        for (genvar gi = 1; gi < DATA_WIDTH; gi++) begin : g_par_chain
            assign par_chain[gi] = par_chain[gi-1] ^ P_DATA[gi];
        end
    endgenerate

    assign accept = (state_reg == IDLE) && Data_Valid;

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
            tx_reg    <= IDLE_BIT;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            tx_reg    <= tx_next;
            busy_reg  <= busy_next;
        end
    end

    // Frame options are frozen at acceptance so mid-frame input changes
    // cannot disturb the frame in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            par_en_reg  <= 1'b0;
            par_bit_reg <= 1'b0;
        end else if (accept) begin
            par_en_reg  <= PAR_EN;
            par_bit_reg <= (PAR_TYP == ODD) ? ~par_chain[DATA_WIDTH-1]
                                            :  par_chain[DATA_WIDTH-1];
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (Data_Valid) state_next = START;
            START:   state_next = DATA;
            DATA: begin
                if (ser_done) begin
                    state_next = par_en_reg ? PARITY : STOP;
                end
            end
            PARITY:  state_next = STOP;
            STOP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output mux, decoded from the state the FSM is about to enter
    // -------------------------------------------------------------------------
    always_comb begin
        tx_next   = IDLE_BIT;
        busy_next = 1'b1;
        unique case (state_next)
            IDLE: begin
                tx_next   = IDLE_BIT;
                busy_next = 1'b0;
            end
            START:   tx_next = START_BIT;
            DATA:    tx_next = ser_data;
            PARITY:  tx_next = par_bit_reg;
            STOP:    tx_next = STOP_BIT;
            default: begin
                tx_next   = IDLE_BIT;
                busy_next = 1'b0;
            end
        endcase
    end

    // Serializer control: shift whenever the next cycle shows a data bit,
    // i.e. when leaving START and on every DATA cycle except the last.
    assign shift_en = (state_next == DATA);
    assign cnt_clr  = (state_reg == START);
    assign cnt_inc  = (state_reg == DATA) && !ser_done;

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .CLK       (CLK),
        .RST       (RST),
        .load      (accept),
        .load_data (P_DATA),
        .shift_en  (shift_en),
        .cnt_clr   (cnt_clr),
        .cnt_inc   (cnt_inc),
        .ser_data  (ser_data),
        .ser_done  (ser_done)
    );

    assign TX_OUT = tx_reg;
    assign busy   = busy_reg;

endmodule : uart_tx_core

// File: tb/tb_uart_tx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_core
// Scoreboard bench for uart_tx_core. Whenever the bench expects a request to
// be accepted it pushes the full per-cycle {TX_OUT, busy} sequence of the
// frame into a queue; a monitor pops one entry per cycle on the falling edge
// and compares it with the DUT, expecting idle (1,0) when the queue is empty.
// -----------------------------------------------------------------------------
module tb_uart_tx_core;

    localparam int W = 8;

    logic         CLK;
    logic         RST;
    logic [W-1:0] P_DATA;
    logic         Data_Valid;
    logic         PAR_EN;
    logic         PAR_TYP;
    logic         TX_OUT;
    logic         busy;

    int checks = 0;
    int errors = 0;

    logic [1:0] exp_q[$];   // {tx, busy} per upcoming cycle
    logic       cur_busy = 1'b0;
    logic       chk_en   = 1'b0;

    uart_tx_core #(
        .DATA_WIDTH (W)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: a request is taken only when the line was idle in that cycle
    // and reset is low; reset discards whatever frame is outstanding.
    always @(posedge CLK) begin
        if (RST) begin
            exp_q.delete();
        end else if (Data_Valid && !cur_busy) begin
            int ones;
            logic p;
            ones = 0;
            for (int i = 0; i < W; i++) ones += int'(P_DATA[i]);
            p = (ones % 2 == 1) ? 1'b1 : 1'b0;
            if (PAR_TYP) p = ~p;
            exp_q.push_back(2'b01);                       // start bit
            for (int i = 0; i < W; i++) exp_q.push_back({P_DATA[i], 1'b1});
            if (PAR_EN) exp_q.push_back({p, 1'b1});       // parity bit
            exp_q.push_back(2'b11);                       // stop bit
            $display("frame: data=%02h par_en=%0d par_typ=%0d at %0t",
                     P_DATA, PAR_EN, PAR_TYP, $time);
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            logic [1:0] e;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else                  e = 2'b10;
            check_eq("tx_out", {31'd0, TX_OUT}, {31'd0, e[1]});
            check_eq("busy",   {31'd0, busy},   {31'd0, e[0]});
            cur_busy = e[0];
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send(input logic [W-1:0] d, input logic pe, input logic pt);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Data_Valid = 1'b1;
        tick(1);
        Data_Valid = 1'b0;
    endtask

    initial begin
        RST        = 1'b1;
        P_DATA     = '0;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        tick(1);
        chk_en = 1'b1;
        tick(2);
        RST = 1'b0;
        tick(2);

        // Plain frame, no parity
        send(8'hA5, 1'b0, 1'b0);
        tick(14);

        // Even then odd parity on the same byte
        send(8'h07, 1'b1, 1'b0);
        tick(14);
        send(8'h07, 1'b1, 1'b1);
        tick(14);

        // Data_Valid held high, payload changed mid-frame
        P_DATA     = 8'h3C;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        Data_Valid = 1'b1;
        tick(5);
        P_DATA = 8'hFF;
        tick(10);
        Data_Valid = 1'b0;
        tick(14);

        // Reset during data bit 3, then a clean frame
        send(8'h55, 1'b0, 1'b0);
        tick(4);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        tick(3);
        send(8'h55, 1'b0, 1'b0);
        tick(14);

        // Reset and request together: reset wins
        RST        = 1'b1;
        Data_Valid = 1'b1;
        P_DATA     = 8'h81;
        tick(1);
        RST        = 1'b0;
        Data_Valid = 1'b0;
        tick(3);

        // Requests during PARITY and STOP are dropped
        send(8'hA5, 1'b1, 1'b0);
        tick(9);
        Data_Valid = 1'b1;
        tick(2);
        Data_Valid = 1'b0;
        tick(6);

        check_eq("drain", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_tx_core
